// File: rtl/spu_ibr_pkg.sv
// Shared types and field layout for the SPU inbound-response buffer.
// Supplies fallback widths for the NoC TID/response macros when the build does not define them.
`ifndef NOU_TID_WIDTH
`define NOU_TID_WIDTH 8
`endif
`ifndef NOU_NOC_RSP_WIDTH
`define NOU_NOC_RSP_WIDTH 16
`endif

package spu_ibr_pkg;

    localparam int ENT_TID_W      = `NOU_TID_WIDTH;
    localparam int RSP_W          = `NOU_NOC_RSP_WIDTH;
    localparam int ENT_TILE_ID_W  = 10;
    localparam int ENT_ERR_CODE_W = 5;
    localparam int ERR_CNT_W      = 8;

    // Bit positions of the decoded fields inside the raw NoC response word
    localparam int TILE_ID_LSB = 0;
    localparam int STATUS_BIT  = ENT_TILE_ID_W;
    localparam int ERR_LSB     = ENT_TILE_ID_W + 1;
    localparam int RSP_USED_W  = ENT_TILE_ID_W + ENT_ERR_CODE_W + 1;

    typedef struct packed {
        logic [ENT_TID_W-1:0]      tid;
        logic [ENT_TILE_ID_W-1:0]  tile_id;
        logic                      status;
        logic [ENT_ERR_CODE_W-1:0] err_code;
    } rsp_entry_t;

endpackage

// File: rtl/spu_ibr_fifo_if.sv
// Inbound NoC response channel plus the decoded head-of-queue channel toward the SPU.
// slave = the buffer, master = the traffic source / response consumer side.
interface spu_ibr_fifo_if;
    import spu_ibr_pkg::*;

    logic                      ib_rsp_vld;
    logic                      ib_rsp_rdy;
    logic [ENT_TID_W-1:0]      ib_rsp_tid;
    logic [RSP_W-1:0]          ib_rsp;

    logic                      rsp_vld;
    logic                      rsp_rdy;
    logic [ENT_TID_W-1:0]      trans_id_q;
    logic [ENT_TILE_ID_W-1:0]  dst_tile_id_q;
    logic                      rsp_status_q;
    logic [ENT_ERR_CODE_W-1:0] rsp_err_code_q;

    modport slave (
        input  ib_rsp_vld, ib_rsp_tid, ib_rsp, rsp_rdy,
        output ib_rsp_rdy, rsp_vld, trans_id_q, dst_tile_id_q, rsp_status_q, rsp_err_code_q
    );

    modport master (
        output ib_rsp_vld, ib_rsp_tid, ib_rsp, rsp_rdy,
        input  ib_rsp_rdy, rsp_vld, trans_id_q, dst_tile_id_q, rsp_status_q, rsp_err_code_q
    );
endinterface

// File: rtl/spu_ibr_ptr.sv
// Read/write pointer pair with an extra wrap bit, full/empty decode and a registered fill count.
// Callers must never push when full or pop when empty.
module spu_ibr_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic                       pop,
    output logic [$clog2(DEPTH)-1:0]   wr_addr,
    output logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] fill_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic [CW-1:0] fill_cnt_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fill_cnt_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + (AW + 1)'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW + 1)'(1);
            if (push && !pop)
                fill_cnt_reg <= fill_cnt_reg + CW'(1);
            else if (pop && !push)
                fill_cnt_reg <= fill_cnt_reg - CW'(1);
        end
    end

    // Same slot index with differing wrap bits means the writer lapped the reader
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign wr_addr  = wr_ptr_reg[AW-1:0];
    assign rd_addr  = rd_ptr_reg[AW-1:0];
    assign fill_cnt = fill_cnt_reg;

endmodule

// File: rtl/spu_ibr_fifo.sv
// SPU inbound-response buffer: decodes NoC responses and queues DEPTH entries toward the SPU.
// Define SPU_IBR_ERR_CNT_EN to add the saturating error-response counter (err_cnt/err_cnt_clr).
module spu_ibr_fifo
    import spu_ibr_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int TILE_ID_W  = ENT_TILE_ID_W,
    parameter int ERR_CODE_W = ENT_ERR_CODE_W
) (
    input  logic                       clk,
    input  logic                       rstn,
    spu_ibr_fifo_if.slave              ib,
    output logic [$clog2(DEPTH+1)-1:0] fill_cnt,
    output logic                       ovf_err,
    input  logic                       ovf_clr
`ifdef SPU_IBR_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]       err_cnt,
    input  logic                       err_cnt_clr
`endif
);
    localparam int AW = $clog2(DEPTH);

    // Entry layout lives in the package, so field widths cannot be overridden per instance
    if (TILE_ID_W != ENT_TILE_ID_W || ERR_CODE_W != ENT_ERR_CODE_W) begin : g_bad_width
        $error("spu_ibr_fifo: TILE_ID_W/ERR_CODE_W must match spu_ibr_pkg");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("spu_ibr_fifo: DEPTH must be a power of two >= 2");
    end
    if (RSP_W > RSP_USED_W) begin : g_spare_bits
        logic unused_rsp_bits;
        assign unused_rsp_bits = ^ib.ib_rsp[RSP_W-1:RSP_USED_W];
    end

    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    rsp_entry_t    wr_entry;
    rsp_entry_t    head;
    rsp_entry_t    mem_reg [DEPTH];
    logic          ovf_err_reg;

    assign push = ib.ib_rsp_vld && !full;
    assign pop  = !empty && ib.rsp_rdy;

    spu_ibr_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push),
        .pop      (pop),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .full     (full),
        .empty    (empty),
        .fill_cnt (fill_cnt)
    );

    assign wr_entry.tid      = ib.ib_rsp_tid;
    assign wr_entry.tile_id  = ib.ib_rsp[TILE_ID_LSB +: ENT_TILE_ID_W];
    assign wr_entry.status   = ib.ib_rsp[STATUS_BIT];
    assign wr_entry.err_code = ib.ib_rsp[ERR_LSB +: ENT_ERR_CODE_W];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (push) begin
            mem_reg[wr_addr] <= wr_entry;
        end
    end

    // Head is read straight from storage; an offered response never bypasses to the head
    assign head              = mem_reg[rd_addr];
    assign ib.trans_id_q     = head.tid;
    assign ib.dst_tile_id_q  = head.tile_id;
    assign ib.rsp_status_q   = head.status;
    assign ib.rsp_err_code_q = head.err_code;
    assign ib.rsp_vld        = !empty;
    assign ib.ib_rsp_rdy     = !full;

    // A refused offer in the same cycle as ovf_clr keeps the flag set
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            ovf_err_reg <= 1'b0;
        else if (ib.ib_rsp_vld && full)
            ovf_err_reg <= 1'b1;
        else if (ovf_clr)
            ovf_err_reg <= 1'b0;
    end
    assign ovf_err = ovf_err_reg;

`ifdef SPU_IBR_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            err_cnt_reg <= '0;
        else if (err_cnt_clr)
            err_cnt_reg <= '0;
        else if (push && wr_entry.status && err_cnt_reg != '1)
            err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
    end
    assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_spu_ibr_fifo.sv
// Directed self-checking bench for spu_ibr_fifo (DEPTH = 4).
// Counter vectors are compiled only when SPU_IBR_ERR_CNT_EN is defined.
module tb_spu_ibr_fifo;
    import spu_ibr_pkg::*;

    localparam int DEPTH = 4;

    logic                       clk;
    logic                       rstn;
    logic                       ovf_clr;
    logic                       ovf_err;
    logic [$clog2(DEPTH+1)-1:0] fill_cnt;
`ifdef SPU_IBR_ERR_CNT_EN
    logic [ERR_CNT_W-1:0]       err_cnt;
    logic                       err_cnt_clr;
`endif

    int n_vec = 0;
    int n_err = 0;

    spu_ibr_fifo_if u_if ();

    spu_ibr_fifo #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .ib          (u_if.slave),
        .fill_cnt    (fill_cnt),
        .ovf_err     (ovf_err),
        .ovf_clr     (ovf_clr)
`ifdef SPU_IBR_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt),
        .err_cnt_clr (err_cnt_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int tid, input logic [15:0] raw);
        u_if.ib_rsp_vld = 1'b1;
        u_if.ib_rsp_tid = ENT_TID_W'(tid);
        u_if.ib_rsp     = RSP_W'(raw);
    endtask

    initial begin
        rstn            = 1'b0;
        ovf_clr         = 1'b0;
        u_if.ib_rsp_vld = 1'b0;
        u_if.ib_rsp_tid = '0;
        u_if.ib_rsp     = '0;
        u_if.rsp_rdy    = 1'b0;
`ifdef SPU_IBR_ERR_CNT_EN
        err_cnt_clr     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk_vec("rst_ib_rdy", u_if.ib_rsp_rdy, 1);
        chk_vec("rst_rsp_vld", u_if.rsp_vld, 0);
        chk_vec("rst_fill", fill_cnt, 0);
        chk_vec("rst_ovf", ovf_err, 0);
        chk_vec("rst_tid_q", u_if.trans_id_q, 0);
        chk_vec("rst_tile_q", u_if.dst_tile_id_q, 0);
        rstn = 1'b1;
        tick();

        // Single push: tid 3, tile 0x2A5, ok status
        offer(3, 16'h02A5);
        tick();
        u_if.ib_rsp_vld = 1'b0;
        chk_vec("p1_vld", u_if.rsp_vld, 1);
        chk_vec("p1_tid", u_if.trans_id_q, 3);
        chk_vec("p1_tile", u_if.dst_tile_id_q, 32'h2A5);
        chk_vec("p1_status", u_if.rsp_status_q, 0);
        chk_vec("p1_err", u_if.rsp_err_code_q, 0);
        chk_vec("p1_fill", fill_cnt, 1);
        u_if.rsp_rdy = 1'b1;
        tick();
        u_if.rsp_rdy = 1'b0;
        chk_vec("p1_pop_vld", u_if.rsp_vld, 0);
        chk_vec("p1_pop_fill", fill_cnt, 0);

        // Error response: err 0x13, status 1, tile 0x155 -> raw 0x9D55
        offer(7, 16'h9D55);
        tick();
        u_if.ib_rsp_vld = 1'b0;
        chk_vec("dec_tid", u_if.trans_id_q, 7);
        chk_vec("dec_tile", u_if.dst_tile_id_q, 32'h155);
        chk_vec("dec_status", u_if.rsp_status_q, 1);
        chk_vec("dec_err", u_if.rsp_err_code_q, 32'h13);
        u_if.rsp_rdy = 1'b1;
        tick();
        u_if.rsp_rdy = 1'b0;

        // Fill to DEPTH with the consumer stalled
        for (int i = 0; i < 4; i++) begin
            offer(i, 16'(i));
            tick();
        end
        chk_vec("full_ib_rdy", u_if.ib_rsp_rdy, 0);
        chk_vec("full_fill", fill_cnt, 4);
        chk_vec("full_ovf0", ovf_err, 0);
        chk_vec("full_head", u_if.trans_id_q, 0);
        // Fifth offer with ovf_clr in the same cycle: set must win
        offer(9, 16'h0009);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk_vec("ovf_set", ovf_err, 1);
        chk_vec("ovf_fill", fill_cnt, 4);

        // Push and pop while full: only the pop happens, ready rises only after the edge
        offer(10, 16'h000A);
        u_if.rsp_rdy = 1'b1;
        #1;
        chk_vec("no_rdy_passthru", u_if.ib_rsp_rdy, 0);
        tick();
        u_if.ib_rsp_vld = 1'b0;
        u_if.rsp_rdy    = 1'b0;
        chk_vec("pp_fill", fill_cnt, 3);
        chk_vec("pp_ib_rdy", u_if.ib_rsp_rdy, 1);
        chk_vec("pp_ovf", ovf_err, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk_vec("ovf_clr", ovf_err, 0);
        for (int i = 1; i < 4; i++) begin
            chk_vec($sformatf("drain_tid%0d", i), u_if.trans_id_q, 32'(i));
            u_if.rsp_rdy = 1'b1;
            tick();
            u_if.rsp_rdy = 1'b0;
        end
        chk_vec("drain_vld", u_if.rsp_vld, 0);
        chk_vec("drain_fill", fill_cnt, 0);

        // Pop request while empty, and no bypass of an offer to the head
        u_if.rsp_rdy = 1'b1;
        tick();
        u_if.rsp_rdy = 1'b0;
        chk_vec("empty_pop_fill", fill_cnt, 0);
        offer(32'h55, 16'h0000);
        #1;
        chk_vec("no_bypass", u_if.rsp_vld, 0);
        tick();
        u_if.ib_rsp_vld = 1'b0;
        chk_vec("bypass_next_tid", u_if.trans_id_q, 32'h55);
        u_if.rsp_rdy = 1'b1;
        tick();
        u_if.rsp_rdy = 1'b0;

        // Streaming push+pop across pointer wrap
        offer(0, 16'h0000);
        tick();
        for (int i = 1; i < 20; i++) begin
            offer(i, 16'h0000);
            u_if.rsp_rdy = 1'b1;
            tick();
            chk_vec($sformatf("stream_tid%0d", i), u_if.trans_id_q, 32'(i));
            chk_vec($sformatf("stream_fill%0d", i), fill_cnt, 1);
        end
        u_if.ib_rsp_vld = 1'b0;
        tick();
        u_if.rsp_rdy = 1'b0;
        chk_vec("stream_end_fill", fill_cnt, 0);

`ifdef SPU_IBR_ERR_CNT_EN
        chk_vec("errcnt_one", err_cnt, 1);
        err_cnt_clr = 1'b1;
        tick();
        err_cnt_clr = 1'b0;
        chk_vec("errcnt_clr", err_cnt, 0);
        u_if.rsp_rdy = 1'b1;
        offer(1, 16'h0400);
        repeat (300) tick();
        chk_vec("errcnt_sat", err_cnt, 255);
        err_cnt_clr = 1'b1;
        tick();
        err_cnt_clr = 1'b0;
        chk_vec("errcnt_clr_wins", err_cnt, 0);
        offer(2, 16'h0000);
        tick();
        chk_vec("errcnt_ok_rsp", err_cnt, 0);
        u_if.ib_rsp_vld = 1'b0;
        tick();
        u_if.rsp_rdy = 1'b0;
        chk_vec("errcnt_drain", fill_cnt, 0);
`endif

        // Reset while entries are queued
        for (int i = 20; i < 25; i++) begin
            offer(i, 16'h0000);
            tick();
        end
        u_if.ib_rsp_vld = 1'b0;
        u_if.rsp_rdy    = 1'b1;
        tick();
        u_if.rsp_rdy    = 1'b0;
        chk_vec("mid_fill", fill_cnt, 3);
        chk_vec("mid_ovf", ovf_err, 1);
        chk_vec("mid_head", u_if.trans_id_q, 21);
        rstn = 1'b0;
        #1;
        chk_vec("arst_vld", u_if.rsp_vld, 0);
        chk_vec("arst_fill", fill_cnt, 0);
        chk_vec("arst_ovf", ovf_err, 0);
        chk_vec("arst_ib_rdy", u_if.ib_rsp_rdy, 1);
        tick();
        rstn = 1'b1;
        tick();
        chk_vec("post_rst_vld", u_if.rsp_vld, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spu_ibr_fifo.md
# spu_ibr_fifo

Parametrised inbound-response buffer for the SPU, successor to the single-entry inbound response register. Accepts NoC responses with their transaction ID, decodes tile ID, status and error code, and queues up to DEPTH entries behind a valid/ready handshake toward the SPU response consumer. Adds backpressure, overflow detection and an optional error-response counter.

## Interface
- DEPTH, 4, entries; power of two, >= 2
- TILE_ID_W, 10, destination tile ID field width
- ERR_CODE_W, 5, error code field width
- clk  in  1  clock
- rstn  in  1  reset. One clock; reset is asynchronous and active-low.
- ib_rsp_vld  in  1  inbound response valid
- ib_rsp_rdy  out  1  buffer can accept; = !full
- ib_rsp_tid  in  `NOU_TID_WIDTH  transaction ID
- ib_rsp  in  `NOU_NOC_RSP_WIDTH  raw response; [TILE_ID_W-1:0] tile ID, [TILE_ID_W] status, [TILE_ID_W+ERR_CODE_W:TILE_ID_W+1] error code
- rsp_vld  out  1  head entry valid
- rsp_rdy  in  1  consumer pops head
- trans_id_q  out  `NOU_TID_WIDTH  head TID
- dst_tile_id_q  out  TILE_ID_W  head tile ID
- rsp_status_q  out  1  head status; 1 = error
- rsp_err_code_q  out  ERR_CODE_W  head error code
- fill_cnt  out  $clog2(DEPTH+1)  occupied entries
- ovf_err  out  1  sticky: response offered while full
- ovf_clr  in  1  clears ovf_err
- err_cnt  out  8  accepted error responses (SPU_IBR_ERR_CNT_EN only)
- err_cnt_clr  in  1  clears err_cnt (SPU_IBR_ERR_CNT_EN only)

## Operation
- Push: ib_rsp_vld & ib_rsp_rdy; fields decoded and written at wr_ptr; wr_ptr++ mod DEPTH.
- Pop: rsp_vld & rsp_rdy; rd_ptr++ mod DEPTH.
- rsp_vld = fill_cnt != 0; head outputs driven from slot rd_ptr, valid only when rsp_vld.
- Simultaneous push and pop: both happen, fill_cnt unchanged.
- Full: ib_rsp_rdy = 0, no write; offered response dropped, ovf_err set.
- Empty: no pop regardless of rsp_rdy; no combinational bypass of ib_rsp to head.
- ovf_err: set on ib_rsp_vld & !ib_rsp_rdy; cleared by ovf_clr; set wins over clear in same cycle.
- Pointers carry an extra wrap bit; full/empty from pointer compare; fill_cnt registered alongside, never exceeds DEPTH.

## Timing
- Reset: ptrs, fill_cnt, storage, all _q outputs, ovf_err, err_cnt = 0; ib_rsp_rdy = 1, rsp_vld = 0.
- Push-to-head latency 1 cycle: push at edge N, rsp_vld high after edge N when previously empty.
- ib_rsp_rdy and rsp_vld are registered-state functions only, no input-to-output combinational path.
- Pop at full raises ib_rsp_rdy the following cycle (no same-cycle pop-to-ready pass-through).
- Reset asserted mid-stream discards all entries immediately.

## Configuration
- SPU_IBR_ERR_CNT_EN defined: err_cnt increments on each accepted push with status = 1, saturates at 255; err_cnt_clr wins over increment.
- Undefined: err_cnt and err_cnt_clr ports absent; no counter logic.

## Structure
- spu_ibr_pkg: rsp_entry_t struct (tid, tile_id, status, err_code), field offset constants, ERR_CNT_W = 8.
- Sub-module spu_ibr_ptr: wrap-bit pointer pair, full/empty, fill_cnt; instantiated once.
- Storage: DEPTH x rsp_entry_t register array, asynchronous reset.

## Test plan
- Reset, then push tid=3, tile=0x2A5, status=0, err=0 -> next cycle rsp_vld=1, outputs match, fill_cnt=1.
- Push 4 entries with rsp_rdy=0 (DEPTH=4) -> ib_rsp_rdy=0, fill_cnt=4; 5th offer sets ovf_err, entry 5 absent on pop.
- Full, push and pop same cycle -> pop accepted, push refused, fill_cnt=3, order tid 0..3 preserved.
- Continuous push/pop 20 cycles across wrap -> TIDs 0..19 in order, fill_cnt steady at 1.
- SPU_IBR_ERR_CNT_EN: 300 pushes with status=1 -> err_cnt=255; err_cnt_clr with push same cycle -> err_cnt=0.
- Assert rstn low with 3 entries queued -> rsp_vld=0, fill_cnt=0, ovf_err=0 immediately.
